// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares one 1602 LCD string driver among NREQ message sources, round-robin when LCDARB_ROUNDROBIN_EN is defined, else fixed priority
module lcd_msg_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned RST_CYCLES   = 262144,
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [256*NREQ-1:0]   msg,
    input  logic [NREQ-1:0]       msg_line,
    output logic [NREQ-1:0]       gnt,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic [255:0]          str,
    output logic                  line,
    output logic                  lcd_reset
);
    typedef enum logic [1:0] {IDLE, CLEAR, SHOW} state_t;
    state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [255:0] str_q, str_d;
    logic line_q, line_d;
    logic [2:0] owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic found;
    logic [2:0] win;
    logic [255:0] win_str;
    logic win_line;
    logic [NREQ-1:0] win_oh;
`ifdef LCDARB_ROUNDROBIN_EN
    logic [2:0] ptr_q, ptr_d;
`endif
    // winner: first request at or above the pointer, then wrap to the lowest set index
    always_comb begin
        found = 1'b0;
        win = '0;
        win_str = '0;
        win_line = 1'b0;
        win_oh = '0;
`ifdef LCDARB_ROUNDROBIN_EN
        for (int i = 0; i < int'(NREQ); i++)
            if (!found && req[i] && i >= int'(ptr_q)) begin
                found = 1'b1;
                win = 3'(i);
                win_str = msg[256*i +: 256];
                win_line = msg_line[i];
                win_oh[i] = 1'b1;
            end
`endif
        for (int i = 0; i < int'(NREQ); i++)
            if (!found && req[i]) begin
                found = 1'b1;
                win = 3'(i);
                win_str = msg[256*i +: 256];
                win_line = msg_line[i];
                win_oh[i] = 1'b1;
            end
    end
    // next state: latch winner in IDLE, count out the clear pulse, then the dwell
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        str_d = str_q;
        line_d = line_q;
        owner_d = owner_q;
        gnt_d = '0;
`ifdef LCDARB_ROUNDROBIN_EN
        ptr_d = ptr_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                state_d = CLEAR;
                cnt_d = RST_CYCLES - 1;
                str_d = win_str;
                line_d = win_line;
                owner_d = win;
                gnt_d = win_oh;
`ifdef LCDARB_ROUNDROBIN_EN
                ptr_d = (int'(win) + 1 == int'(NREQ)) ? 3'd0 : win + 3'd1;
`endif
            end
            CLEAR: begin
                cnt_d = (cnt_q == 0) ? DWELL_CYCLES - 1 : cnt_q - 1;
                state_d = (cnt_q == 0) ? SHOW : CLEAR;
            end
            SHOW: begin
                cnt_d = (cnt_q == 0) ? 32'd0 : cnt_q - 1;
                state_d = (cnt_q == 0) ? IDLE : SHOW;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers, cleared immediately by the async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            str_q <= '0;
            line_q <= 1'b0;
            owner_q <= '0;
            gnt_q <= '0;
`ifdef LCDARB_ROUNDROBIN_EN
            ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            str_q <= str_d;
            line_q <= line_d;
            owner_q <= owner_d;
            gnt_q <= gnt_d;
`ifdef LCDARB_ROUNDROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end
    assign gnt = gnt_q;
    assign owner = owner_q;
    assign str = str_q;
    assign line = line_q;
    assign busy = state_q != IDLE;
    assign lcd_reset = state_q == CLEAR;
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// tb_lcd_msg_arbiter: directed self-checking bench for lcd_msg_arbiter
module tb_lcd_msg_arbiter;
    localparam int NREQ = 4;
    localparam int RST_CYCLES = 4;
    localparam int DWELL_CYCLES = 10;
    logic clk = 1'b0;
    logic reset;
    logic [NREQ-1:0] req, msg_line, gnt;
    logic [256*NREQ-1:0] msg;
    logic [2:0] owner;
    logic busy, line, lcd_reset;
    logic [255:0] str;
    int checks = 0;
    int errors = 0;
    int n;
    int exp_own [5];
    logic seen3;

    lcd_msg_arbiter #(.NREQ(NREQ), .RST_CYCLES(RST_CYCLES), .DWELL_CYCLES(DWELL_CYCLES)) dut (
        .clk(clk), .reset(reset), .req(req), .msg(msg), .msg_line(msg_line),
        .gnt(gnt), .owner(owner), .busy(busy), .str(str), .line(line), .lcd_reset(lcd_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (gnt == 0 && cnt < 40);
        checks++;
        assert (gnt != 0) else begin
            errors++;
            $error("FAIL gnt_timeout observed=0 expected=nonzero");
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
`ifdef LCDARB_ROUNDROBIN_EN
        exp_own = '{0, 1, 2, 3, 0};
`else
        exp_own = '{0, 0, 0, 0, 0};
`endif
        reset = 1'b1;
        req = '0;
        msg = '0;
        msg_line = '0;
        @(negedge clk);
        chk("rst_gnt", 256'(gnt), 0);
        chk("rst_owner", 256'(owner), 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_str", str, 0);
        chk("rst_lcd_reset", 256'(lcd_reset), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", 256'(busy), 0);
        chk("idle_gnt", 256'(gnt), 0);
        chk("idle_line", 256'(line), 0);

        msg[2*256 +: 256] = 256'h4F4C4C4548;
        msg_line = 4'b0100;
        req = 4'b0100;
        @(negedge clk);
        chk("hello_gnt", 256'(gnt), 4'b0100);
        chk("hello_owner", 256'(owner), 2);
        chk("hello_line", 256'(line), 1);
        chk("hello_str", str, 256'h4F4C4C4548);
        chk("hello_lcd_reset", 256'(lcd_reset), 1);
        chk("hello_busy", 256'(busy), 1);
        req = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) chk("hello_gnt_pulse", 256'(gnt), 0);
            chk("hello_lcd_reset_seq", 256'(lcd_reset), 256'(k < 4));
            chk("hello_busy_seq", 256'(busy), 256'(k < 14));
        end
        chk("hello_str_held", str, 256'h4F4C4C4548);
        chk("hello_owner_held", 256'(owner), 2);

        pulse_reset();
        for (int i = 0; i < NREQ; i++) msg[256*i +: 256] = 256'(8'h41 + i);
        msg_line = '0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(n);
            chk("rr_spacing", 256'(n), (g == 0) ? 256'd1 : 256'd15);
            chk("rr_owner", 256'(owner), 256'(exp_own[g]));
            chk("rr_gnt", 256'(gnt), 256'(4'b0001 << exp_own[g]));
            chk("rr_str", str, 256'(8'h41 + exp_own[g]));
        end
        req = '0;
        repeat (16) @(negedge clk);

        pulse_reset();
        req = 4'b0001;
        wait_gnt(n);
        chk("late_owner0", 256'(owner), 0);
        req = '0;
        repeat (6) @(negedge clk);
        req = 4'b0010;
        msg[256 +: 256] = 256'h58;
        repeat (2) @(negedge clk);
        chk("late_str_hold1", str, 256'h41);
        msg[256 +: 256] = 256'h59;
        repeat (2) @(negedge clk);
        chk("late_str_hold2", str, 256'h41);
        chk("late_no_gnt", 256'(gnt), 0);
        wait_gnt(n);
        chk("late_gnt", 256'(gnt), 4'b0010);
        chk("late_str", str, 256'h59);
        chk("late_wait", 256'(n), 5);
        req = '0;

        repeat (6) @(negedge clk);
        req = 4'b1000;
        seen3 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen3 |= gnt[3];
        end
        req = '0;
        repeat (12) begin
            @(negedge clk);
            seen3 |= gnt[3];
        end
        chk("withdraw_no_gnt3", 256'(seen3), 0);
        chk("withdraw_idle", 256'(busy), 0);
        chk("withdraw_owner", 256'(owner), 1);

        req = 4'b0001;
        wait_gnt(n);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_lcd_reset", 256'(lcd_reset), 0);
        chk("arst_busy", 256'(busy), 0);
        chk("arst_str", str, 0);
        chk("arst_owner", 256'(owner), 0);
        req = 4'b1010;
        @(negedge clk);
        reset = 1'b0;
        wait_gnt(n);
        chk("arst_first_wait", 256'(n), 1);
        chk("arst_first_gnt", 256'(gnt), 4'b0010);
        chk("arst_first_owner", 256'(owner), 1);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
